// File: rtl/spi_master_gen_pkg.sv
// spi_pkg: shared types and constants for the SPI master.
//   spi_state_t : transfer FSM states
//   MODE0..3    : SPI modes encoded as {cpol, cpha}
//   cs_none()   : the chip-select index meaning "no CS asserted"
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Any cs_sel at or above this index leaves every CS deasserted.
    function automatic int cs_none(input int num_cs);
        return num_cs;
    endfunction

endpackage

// File: rtl/spi_master_gen_if.sv
// spi_master_gen_if: control/status handshake plus the SPI pins.
//   master modport : seen by the SPI master (spi_master_gen)
//   slave  modport : seen by the controlling logic / SPI device side
interface spi_master_gen_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 2,
    parameter int DIV_W  = 8
);
    localparam int CS_W = $clog2(NUM_CS) + 1;

    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic [CS_W-1:0]   cs_sel;
    logic              hold_cs;
    logic              cs_release;
    logic              cpol;
    logic              cpha;
    logic [DIV_W-1:0]  clk_div;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;
    logic              spiCLK;
    logic [NUM_CS-1:0] spiCS;
    logic              spiMOSI;
    logic              spiMISO;

    modport master (
        input  start, tx_data, cs_sel, hold_cs, cs_release, cpol, cpha, clk_div, spiMISO,
        output busy, done, rx_data, spiCLK, spiCS, spiMOSI
    );

    modport slave (
        output start, tx_data, cs_sel, hold_cs, cs_release, cpol, cpha, clk_div, spiMISO,
        input  busy, done, rx_data, spiCLK, spiCS, spiMOSI
    );

endinterface

// File: rtl/spi_master_gen_half_tick.sv
// spi_half_tick: loadable down-counter producing a one-cycle tick every
// (i_load_val + 1) cycles while enabled. The tick marks the last cycle of
// each SPI half-period.
//   clk, srst   : clock, synchronous active-high reset
//   i_load      : latch i_load_val as both current count and reload value
//   i_load_val  : divider value (half-period minus one)
//   i_en        : count enable
//   o_tick      : high in the final cycle of each half-period
module spi_half_tick #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_tick
);
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_reload;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_cnt    <= '0;
            r_reload <= '0;
        end else if (i_load) begin
            r_cnt    <= i_load_val;
            r_reload <= i_load_val;
        end else if (i_en) begin
            if (r_cnt == '0) r_cnt <= r_reload;
            else             r_cnt <= r_cnt - DIV_W'(1);
        end
    end

    assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/spi_master_gen.sv
// spi_master_gen: parametrised SPI master (all four modes, runtime divider,
// multiple active-low chip selects, optional CS hold across words).
//   clk50, reset : clock, synchronous active-high reset
//   bus          : spi_master_gen_if.master -- start/tx_data/cs_sel/hold_cs/
//                  cs_release/cpol/cpha/clk_div in, busy/done/rx_data out,
//                  spiCLK/spiCS/spiMOSI out, spiMISO in
module spi_master_gen
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 2,
    parameter int DIV_W  = 8
) (
    input  logic clk50,
    input  logic reset,
    spi_master_gen_if.master bus
);
    localparam int CS_W   = $clog2(NUM_CS) + 1;
    localparam int EDGE_W = $clog2(2 * DATA_W) + 1;
    localparam logic [EDGE_W-1:0] LAST_EDGE   = EDGE_W'(2 * DATA_W);
    localparam logic [CS_W-1:0]   CS_NONE_IDX = CS_W'(cs_none(NUM_CS));

    spi_state_t        r_state;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_rx_data;
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] r_tx;
    logic [EDGE_W-1:0] r_edge;
    logic [NUM_CS-1:0] r_cs;
    logic              r_sclk;
    logic              r_mosi;
    logic              r_cpol;
    logic              r_cpha;
    logic              r_hold;

    logic              w_tick;
    logic              w_load;
    logic              w_edge_evt;
    logic              w_sample;
    logic [NUM_CS-1:0] w_cs_dec;

    assign w_load = (r_state == IDLE) && bus.start;

    spi_half_tick #(.DIV_W(DIV_W)) u_tick (
        .clk        (clk50),
        .srst       (reset),
        .i_load     (w_load),
        .i_load_val (bus.clk_div),
        .i_en       (r_state != IDLE),
        .o_tick     (w_tick)
    );

    // Active-low one-hot decode; out-of-range selects leave all lines high.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
            assign w_cs_dec[gi] = !((bus.cs_sel == CS_W'(gi)) && (bus.cs_sel < CS_NONE_IDX));
        end
    endgenerate

    // The SETUP-ending tick is edge 0; XFER ticks are edges 1..2*DATA_W-1,
    // and the tick with r_edge == LAST_EDGE only closes the last half-period.
    assign w_edge_evt = w_tick && ((r_state == SETUP) ||
                                   ((r_state == XFER) && (r_edge != LAST_EDGE)));
    // Even edges sample when cpha=0, odd edges sample when cpha=1.
    assign w_sample   = (r_edge[0] == r_cpha);

    always_ff @(posedge clk50) begin
        if (reset) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rx_data <= '0;
            r_rx      <= '0;
            r_tx      <= '1;
            r_edge    <= '0;
            r_cs      <= '1;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b1;
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_hold    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_sclk <= bus.cpol;
                    r_mosi <= 1'b1;
                    if (bus.start) begin
                        r_state <= SETUP;
                        r_busy  <= 1'b1;
                        r_cpol  <= bus.cpol;
                        r_cpha  <= bus.cpha;
                        r_hold  <= bus.hold_cs;
                        r_edge  <= '0;
                        // Also drops a held CS on a different line.
                        r_cs    <= w_cs_dec;
                        if (bus.cpha) begin
                            // MSB goes out on edge 0.
                            r_mosi <= 1'b1;
                            r_tx   <= bus.tx_data;
                        end else begin
                            // MSB is presented before the first edge.
                            r_mosi <= bus.tx_data[DATA_W-1];
                            r_tx   <= {bus.tx_data[DATA_W-2:0], 1'b1};
                        end
                    end else if (bus.cs_release) begin
                        r_cs <= '1;
                    end
                end
                SETUP: begin
                    if (w_tick) r_state <= XFER;
                end
                XFER: begin
                    if (w_tick && (r_edge == LAST_EDGE)) begin
                        r_state <= HOLD;
                        r_sclk  <= r_cpol;
                        r_mosi  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (w_tick) begin
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_rx_data <= r_rx;
                        if (!r_hold) r_cs <= '1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_edge_evt) begin
                r_sclk <= ~r_sclk;
                r_edge <= r_edge + EDGE_W'(1);
                if (w_sample) begin
                    r_rx <= {r_rx[DATA_W-2:0], bus.spiMISO};
                end else begin
                    // Fill with ones so MOSI idles high past the last bit.
                    r_mosi <= r_tx[DATA_W-1];
                    r_tx   <= {r_tx[DATA_W-2:0], 1'b1};
                end
            end
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.rx_data = r_rx_data;
    assign bus.spiCLK  = r_sclk;
    assign bus.spiCS   = r_cs;
    assign bus.spiMOSI = r_mosi;

endmodule

// File: tb/tb_spi_master_gen.sv
// tb_spi_master_gen: directed bench for spi_master_gen (DATA_W=8, NUM_CS=2).
// A behavioural SPI slave returns 8'h3C and records MOSI on sampling edges.
module tb_spi_master_gen;
    import spi_pkg::*;

    logic clk50 = 1'b0;
    logic reset = 1'b1;
    always #5 clk50 = ~clk50;

    spi_master_gen_if #(.DATA_W(8), .NUM_CS(2), .DIV_W(8)) bus ();

    spi_master_gen #(.DATA_W(8), .NUM_CS(2), .DIV_W(8)) dut (
        .clk50 (clk50),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // ---------------- slave model / monitor ----------------
    logic [7:0] pat = 8'h3C;
    logic       miso_r = 1'b0;
    logic       cur_cpha = 1'b0;
    logic       prev_busy = 1'b0;
    logic       prev_sclk = 1'b0;
    logic [7:0] mosi_cap = 8'h00;
    int         ecount = 0;
    int         shifts = 0;
    int         tot_edges = 0;
    bit         idle_test = 1'b0;
    int         idle_viol = 0;
    bit         cs_watch = 1'b0;
    bit         cs_armed = 1'b0;
    int         cs_viol = 0;
    int         onehot_viol = 0;

    assign bus.spiMISO = miso_r;

    always @(negedge clk50) begin
        int idx;
        if (bus.busy && !prev_busy) begin
            ecount   = 0;
            shifts   = 0;
            mosi_cap = 8'h00;
        end
        if (!bus.busy) miso_r = pat[7];
        if (bus.busy && (bus.spiCLK != prev_sclk)) begin
            tot_edges++;
            if (ecount[0] == cur_cpha) begin
                mosi_cap = {mosi_cap[6:0], bus.spiMOSI};
            end else begin
                idx    = cur_cpha ? (7 - shifts) : (6 - shifts);
                miso_r = (idx >= 0) ? pat[idx] : 1'b1;
                shifts++;
            end
            ecount++;
        end
        if (idle_test && bus.busy && ((bus.spiCS != 2'b11) || (bus.spiMOSI != 1'b1))) idle_viol++;
        if (cs_watch && !bus.spiCS[0]) cs_armed = 1'b1;
        if (cs_watch && cs_armed && bus.spiCS[0] && (bus.busy || !bus.done)) cs_viol++;
        if ($countones(~bus.spiCS) > 1) onehot_viol++;
        prev_busy = bus.busy;
        prev_sclk = bus.spiCLK;
    end

    // ---------------- transfer driver ----------------
    task automatic do_xfer(input logic [7:0] tx, input logic [1:0] cs, input logic hold,
                           input logic [1:0] mode, input logic [7:0] div, input int poke,
                           output int busy_cyc, output logic got_done, output logic idle_sclk);
        @(posedge clk50); #1;
        bus.tx_data = tx;
        bus.cs_sel  = cs;
        bus.hold_cs = hold;
        bus.cpol    = mode[1];
        bus.cpha    = mode[0];
        bus.clk_div = div;
        cur_cpha    = mode[0];
        @(posedge clk50); #1;
        idle_sclk = bus.spiCLK;
        bus.start = 1'b1;
        @(posedge clk50); #1;
        bus.start = 1'b0;
        busy_cyc  = 0;
        got_done  = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk50);
            if (i == poke) begin
                bus.start   = 1'b1;
                bus.tx_data = 8'h00;
            end
            if (i == poke + 1) bus.start = 1'b0;
            if (bus.busy) busy_cyc++;
            else begin
                got_done = bus.done;
                break;
            end
        end
    endtask

    initial begin
        int         bc;
        logic       gd;
        logic       isc;
        int         cnt;
        logic [1:0] modes [3];
        logic [1:0] hold_seq [4];
        modes    = '{MODE1, MODE2, MODE3};
        hold_seq = '{2'b01, 2'b01, 2'b01, 2'b00};

        bus.start = 1'b0; bus.tx_data = 8'h00; bus.cs_sel = 2'd0; bus.hold_cs = 1'b0;
        bus.cs_release = 1'b0; bus.cpol = 1'b1; bus.cpha = 1'b0; bus.clk_div = 8'd0;

        // Reset values (cpol input high so spiCLK=0 is meaningful)
        repeat (3) @(posedge clk50);
        #1;
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_done", 32'(bus.done), 32'd0);
        check_val("rst_rx",   32'(bus.rx_data), 32'h00);
        check_val("rst_sclk", 32'(bus.spiCLK), 32'd0);
        check_val("rst_cs",   32'(bus.spiCS), 32'h3);
        check_val("rst_mosi", 32'(bus.spiMOSI), 32'd1);
        reset = 1'b0;

        // Mode 0, fastest clock
        tot_edges = 0;
        do_xfer(8'hA5, 2'd0, 1'b0, MODE0, 8'd0, -10, bc, gd, isc);
        $display("xfer mode0 div0 tx=a5 rx=%h mosi=%h busy=%0d", bus.rx_data, mosi_cap, bc);
        check_val("m0_busy",  32'(bc), 32'd18);
        check_val("m0_done",  32'(gd), 32'd1);
        check_val("m0_rx",    32'(bus.rx_data), 32'h3C);
        check_val("m0_mosi",  32'(mosi_cap), 32'hA5);
        check_val("m0_edges", 32'(tot_edges), 32'd16);
        check_val("m0_cs",    32'(bus.spiCS), 32'h3);

        // Modes 1..3 with divider 3
        for (int m = 0; m < 3; m++) begin
            do_xfer(8'hA5, 2'd0, 1'b0, modes[m], 8'd3, -10, bc, gd, isc);
            $display("xfer mode%0d div3 tx=a5 rx=%h mosi=%h busy=%0d", modes[m], bus.rx_data, mosi_cap, bc);
            check_val("md_idle", 32'(isc), 32'(modes[m][1]));
            check_val("md_busy", 32'(bc), 32'd72);
            check_val("md_done", 32'(gd), 32'd1);
            check_val("md_rx",   32'(bus.rx_data), 32'h3C);
            check_val("md_mosi", 32'(mosi_cap), 32'hA5);
        end

        // Held CS across four words on cs_sel 0
        cs_viol = 0; cs_armed = 1'b0; cs_watch = 1'b1;
        for (int w = 0; w < 4; w++) begin
            do_xfer(8'h5A, 2'd0, hold_seq[w][0], MODE0, 8'd1, -10, bc, gd, isc);
            $display("xfer hold word%0d hold=%0d cs=%b rx=%h", w, hold_seq[w][0], bus.spiCS, bus.rx_data);
            check_val("hold_cs0", 32'(bus.spiCS[0]), 32'(!hold_seq[w][0]));
        end
        cs_watch = 1'b0;
        check_val("hold_gap", 32'(cs_viol), 32'd0);

        // Idle clocks with no CS asserted
        idle_viol = 0; tot_edges = 0; idle_test = 1'b1;
        for (int r = 0; r < 10; r++) begin
            do_xfer(8'hFF, 2'(cs_none(2)), 1'b0, MODE0, 8'd0, -10, bc, gd, isc);
            $display("xfer idle-clock %0d cs=%b busy=%0d", r, bus.spiCS, bc);
        end
        idle_test = 1'b0;
        check_val("idle_edges", 32'(tot_edges), 32'd160);
        check_val("idle_viol",  32'(idle_viol), 32'd0);

        // start during busy is ignored
        do_xfer(8'hA5, 2'd1, 1'b0, MODE0, 8'd0, 5, bc, gd, isc);
        $display("xfer start-poke busy=%0d mosi=%h", bc, mosi_cap);
        check_val("poke_busy", 32'(bc), 32'd18);
        check_val("poke_mosi", 32'(mosi_cap), 32'hA5);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk50);
            if (bus.busy) cnt++;
        end
        check_val("poke_noq", 32'(cnt), 32'd0);

        // Hold cs1, then move to cs0: cs1 drops on SETUP entry
        do_xfer(8'h11, 2'd1, 1'b1, MODE0, 8'd0, -10, bc, gd, isc);
        check_val("sw_held", 32'(bus.spiCS), 32'h1);
        do_xfer(8'h22, 2'd0, 1'b0, MODE0, 8'd0, -10, bc, gd, isc);
        $display("xfer cs-switch cs=%b", bus.spiCS);
        check_val("sw_end", 32'(bus.spiCS), 32'h3);

        // cs_release in IDLE
        do_xfer(8'h33, 2'd1, 1'b1, MODE0, 8'd0, -10, bc, gd, isc);
        @(posedge clk50); #1;
        check_val("rel_before", 32'(bus.spiCS), 32'h1);
        bus.cs_release = 1'b1;
        @(posedge clk50); #1;
        bus.cs_release = 1'b0;
        $display("xfer cs-release cs=%b", bus.spiCS);
        check_val("rel_after", 32'(bus.spiCS), 32'h3);

        // Reset in the middle of XFER (mode 2, CS held)
        bus.tx_data = 8'hA5; bus.cs_sel = 2'd0; bus.hold_cs = 1'b1;
        bus.cpol = 1'b1; bus.cpha = 1'b0; bus.clk_div = 8'd3; cur_cpha = 1'b0;
        @(posedge clk50); #1;
        bus.start = 1'b1;
        @(posedge clk50); #1;
        bus.start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk50);
            if (ecount >= 5) break;
            cnt++;
        end
        check_val("rst_reach", 32'(cnt < 500), 32'd1);
        reset = 1'b1;
        @(posedge clk50); #1;
        $display("xfer reset-mid busy=%0d cs=%b sclk=%0d rx=%h", bus.busy, bus.spiCS, bus.spiCLK, bus.rx_data);
        check_val("mid_busy", 32'(bus.busy), 32'd0);
        check_val("mid_done", 32'(bus.done), 32'd0);
        check_val("mid_rx",   32'(bus.rx_data), 32'h00);
        check_val("mid_sclk", 32'(bus.spiCLK), 32'd0);
        check_val("mid_cs",   32'(bus.spiCS), 32'h3);
        check_val("mid_mosi", 32'(bus.spiMOSI), 32'd1);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk50);
            if (bus.done || bus.busy) cnt++;
        end
        check_val("mid_nodone", 32'(cnt), 32'd0);
        check_val("onehot", 32'(onehot_viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
